// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle issue controller in front of the 64-bit ALU.
// Accepts one decoded instruction beat, drives the ALU operands/control for
// one settle cycle, captures the result and zero flag, then presents a
// write-back/branch response.
//
// Handshakes: a beat transfers on a rising edge where valid && ready are both
// high. instr_ready is high only in IDLE. res_valid is high only in RESP, and
// every res_* / branch_taken / illegal output is held stable until the
// response transfers. The two handshakes never complete in the same cycle.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [63:0] rs1_val,
  input  logic [63:0] rs2_val,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  alu_f3,
  output logic [1:0]  alu_f7,
  input  logic [63:0] alu_result,
  input  logic        alu_zf,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic [4:0]  res_rd,
  output logic        res_wen,
  output logic        branch_taken,
  output logic        illegal,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t state, next_state;

  logic        accept;
  logic        resp_done;
  logic [63:0] imm_i;
  logic [63:0] imm_s;
  logic [63:0] dec_a;
  logic [63:0] dec_b;
  logic [1:0]  dec_op;
  logic        dec_wen;
  logic        dec_illegal;
  logic        dec_branch;
  logic        is_branch_q;
  logic [2:0]  br_f3_q;

  assign accept      = (state == IDLE) && instr_valid;
  assign resp_done   = (state == RESP) && res_ready;
  assign instr_ready = (state == IDLE);
  assign res_valid   = (state == RESP);
  assign dbg_state   = state;

  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};

  // Decode the offered instruction into ALU drive values and response flags.
  always_comb begin
    dec_a       = rs1_val;
    dec_b       = rs2_val;
    dec_op      = 2'b00;
    dec_wen     = 1'b0;
    dec_illegal = 1'b0;
    dec_branch  = 1'b0;
    case (instr[6:0])
      OP_R: begin
        dec_op  = 2'b10;
        dec_wen = 1'b1;
      end
      OP_IMM, OP_LOAD: begin
        dec_b   = imm_i;
        dec_wen = 1'b1;
      end
      OP_STORE: begin
        dec_b = imm_s;
      end
      OP_BRANCH: begin
        dec_op     = 2'b01;
        dec_branch = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; unsupported opcodes bypass the ALU and go straight to RESP.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = dec_illegal ? RESP : ISSUE;
      end
      ISSUE:   next_state = CAPTURE;
      CAPTURE: next_state = RESP;
      RESP: begin
        if (resp_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers: ALU drive latched at accept, result/branch resolved in CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      alu_f3       <= '0;
      alu_f7       <= '0;
      res_data     <= '0;
      res_rd       <= '0;
      res_wen      <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      is_branch_q  <= 1'b0;
      br_f3_q      <= '0;
    end else if (accept) begin
      alu_a        <= dec_a;
      alu_b        <= dec_b;
      alu_op       <= dec_op;
      alu_f3       <= instr[13:12];
      alu_f7       <= instr[31:30];
      res_rd       <= instr[11:7];
      // x0 is hardwired, so a write to it is never requested.
      res_wen      <= dec_wen && (instr[11:7] != 5'd0);
      branch_taken <= 1'b0;
      illegal      <= dec_illegal;
      is_branch_q  <= dec_branch;
      br_f3_q      <= instr[14:12];
    end else if (state == CAPTURE) begin
      res_data <= alu_result;
      if (is_branch_q) begin
        case (br_f3_q)
          3'b000:  branch_taken <= alu_zf;
          3'b001:  branch_taken <= !alu_zf;
          default: illegal      <= 1'b1;
        endcase
      end
    end
  end

endmodule
